// File: rtl/property_sweeper.sv
// rtl/property_sweeper.sv - exhaustive stimulus sweeper and property checker for combinational blocks
// Optional: SWEEP_STOP_ON_FAIL_EN ends the sweep at the first failing vector.
module property_sweeper #(
  parameter int NUM_INPUTS = 4,
  parameter int NUM_PROPS  = 9,
  parameter int SETTLE     = 1,
  parameter logic [NUM_PROPS-1:0] ONE_MASK  = 9'h1FC,
  parameter logic [NUM_PROPS-1:0] ZERO_MASK = 9'h002,
  parameter logic [NUM_PROPS-1:0] A_MASK    = 9'h000,
  localparam int CNT_W = NUM_INPUTS + 1
) (
  input  logic                  clk,
  input  logic                  rst_n,
  input  logic                  start,
  input  logic                  abort,
  input  logic [NUM_PROPS-1:0]  props,
  output logic [NUM_INPUTS-1:0] stim,
  output logic                  busy,
  output logic                  done,
  output logic                  pass,
  output logic [NUM_PROPS-1:0]  fail_mask,
  output logic [CNT_W-1:0]      fail_count,
  output logic                  first_fail_valid,
  output logic [NUM_INPUTS-1:0] first_fail_vec
);

  localparam logic [1:0] IDLE   = 2'd0;
  localparam logic [1:0] DRIVE  = 2'd1;
  localparam logic [1:0] SAMPLE = 2'd2;
  localparam logic [1:0] DONE   = 2'd3;

  localparam int SW = (SETTLE > 1) ? $clog2(SETTLE) : 1;
  localparam logic [SW-1:0] SETTLE_LAST = SW'(SETTLE - 1);
  localparam logic [NUM_PROPS-1:0] CARE_MASK = ONE_MASK | ZERO_MASK | A_MASK;

  logic [1:0]           state;
  logic [SW-1:0]        settle;
  logic [NUM_PROPS-1:0] expected;
  logic [NUM_PROPS-1:0] mism;

  // Bits outside ONE/ZERO follow a; only the care mask decides whether they count.
  always_comb begin
    expected = ONE_MASK | ({NUM_PROPS{stim[0]}} & ~ONE_MASK & ~ZERO_MASK);
    mism     = (props ^ expected) & CARE_MASK;
  end

  assign busy = (state == DRIVE) || (state == SAMPLE);
  assign done = (state == DONE);
  assign pass = done && (fail_count == '0);

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state            <= IDLE;
      settle           <= '0;
      stim             <= '0;
      fail_mask        <= '0;
      fail_count       <= '0;
      first_fail_valid <= 1'b0;
      first_fail_vec   <= '0;
    end else if (abort) begin
      // Statistics are kept so a supervisor can inspect a partial sweep.
      state  <= IDLE;
      stim   <= '0;
      settle <= '0;
    end else begin
      case (state)
        IDLE, DONE: begin
          if (start) begin
            state            <= DRIVE;
            stim             <= '0;
            settle           <= '0;
            fail_mask        <= '0;
            fail_count       <= '0;
            first_fail_valid <= 1'b0;
            first_fail_vec   <= '0;
          end
        end
        DRIVE: begin
          if (settle == SETTLE_LAST) begin
            state  <= SAMPLE;
            settle <= '0;
          end else begin
            settle <= settle + SW'(1);
          end
        end
        SAMPLE: begin
          if (|mism) begin
            fail_mask <= fail_mask | mism;
            if (!(&fail_count))
              fail_count <= fail_count + CNT_W'(1);
            if (!first_fail_valid) begin
              first_fail_valid <= 1'b1;
              first_fail_vec   <= stim;
            end
          end
`ifdef SWEEP_STOP_ON_FAIL_EN
          if ((|mism) || (&stim)) begin
            state <= DONE;
          end else begin
            stim  <= stim + NUM_INPUTS'(1);
            state <= DRIVE;
          end
`else
          if (&stim) begin
            state <= DONE;
          end else begin
            stim  <= stim + NUM_INPUTS'(1);
            state <= DRIVE;
          end
`endif
        end
        default: state <= IDLE;
      endcase
    end
  end

endmodule
